ae_program_sequencer: RTL and testbench
=======================================

Name: ae_program_sequencer

Overview:
- Parametrised successor to the autoencoder's free-running instruction counter and instruction memory fetch path.
- Adds start/done handshake, a HALT opcode, a single-level hardware loop (LOOP_SET/LOOP_END), datapath stall and PC wrap.
- Drives the address of an external synchronous instruction memory.
- Issues decoded opcode and field outputs to the CU/ALU/memory-selector datapath.

Parameters:
- INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1:INSTR_W-4], then three FIELD_W fields, MSB first.
- FIELD_W, 4, width of each operand field; INSTR_W must equal 4+3*FIELD_W.
- PC_W, 5, program counter/address width; program depth is 2^PC_W.
- LOOP_W, 8, loop counter width; count is taken from instr[LOOP_W-1:0] (LOOP_W <= 3*FIELD_W).

Ports:
- clock, in, 1, single clock; all state updates on rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, level; sampled in IDLE only.
- start_pc, in, PC_W, first instruction address, captured when start is accepted.
- instr_addr, out, PC_W, registered address to the instruction memory.
- instr_data, in, INSTR_W, memory read data, valid one cycle after instr_addr.
- stall, in, 1, datapath not ready; holds the current issue.
- issue_valid, out, 1, opcode/fields valid for the datapath this cycle.
- opcode, out, 4, issued opcode.
- field_1 / field_2 / field_3, out, FIELD_W each, issued operand fields (read-1, read-2, write).
- busy, out, 1, high whenever not in IDLE.
- done, out, 1, one-cycle pulse on HALT.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, pc=0, instr_addr=0, loop_cnt=0, loop_start=0.
- Reset values of outputs: issue_valid=0, opcode=0, fields=0, busy=0, done=0.
- Reset mid-program aborts immediately. No done is produced.
- States: IDLE, FETCH, EXEC.
- IDLE:
  - start=1 -> pc<=start_pc, instr_addr<=start_pc, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: one wait cycle for memory latency, then go to EXEC. Outputs are not valid in FETCH.
- EXEC: decode instr_data (registered into opcode/fields on entry, so issue is combinational from the latch).
  - Opcodes 0x0-0xC (datapath ops):
    - issue_valid=1.
    - If stall=1, hold in EXEC with opcode/fields stable and issue_valid held high.
    - When stall=0, the issue completes that cycle: pc<=pc+1, instr_addr<=pc+1, go to FETCH.
  - 0xD LOOP_SET:
    - loop_cnt<=instr[LOOP_W-1:0], loop_start<=pc+1.
    - pc advance as above; issue_valid=0; stall is ignored.
  - 0xE LOOP_END:
    - If loop_cnt!=0: loop_cnt<=loop_cnt-1, pc<=loop_start.
    - Else: fall through to pc+1.
    - issue_valid=0.
    - A body executes count+1 times in total. Count 0 means a single pass.
  - 0xF HALT: done=1 for exactly one cycle, go to IDLE, pc is retained, issue_valid=0.
- Throughput: 2 cycles per instruction with no stall.
  - start accepted in cycle N -> first issue_valid in cycle N+2.
- PC wrap: pc+1 at 2^PC_W-1 wraps to 0, with no error. loop_start wraps the same way.
- Nesting: LOOP_SET inside an active loop overwrites loop_cnt/loop_start. There is no stack.
- LOOP_END with loop_cnt=0 (including when no LOOP_SET was seen) falls through.
- start while busy is ignored. start in the same cycle as the done pulse is ignored; start is re-sampled next cycle in IDLE.
- busy=1 in FETCH and EXEC, including the HALT EXEC cycle. busy=0 from the cycle after done.
- Arithmetic: pc and loop counter are modular unsigned, at PC_W and LOOP_W bits.

Test Plan:
- Straight line: program {0x1123, 0x2456, 0xF000} at 0, start_pc=0.
  - Expect issues (1,1,2,3) at N+2 and (2,4,5,6) at N+4.
  - done at N+6, busy low at N+7.
- Stall: stall=1 for 3 cycles during the first issue.
  - opcode/fields and issue_valid stay stable for 4 cycles.
  - instr_addr does not advance; the second issue is delayed by exactly 3 cycles.
- Loop: {LOOP_SET count=2 (0xD002), 0x3111, LOOP_END (0xE000), 0xF000}.
  - Expect exactly 3 issues of 0x3111, then done; loop_cnt ends at 0.
- Wrap: PC_W=5, start_pc=31, mem[31]=0x1000, mem[0]=0xF000.
  - Expect one issue, then instr_addr=0, then done.
- Reset mid-run: assert reset_n=0 during EXEC of a stalled issue.
  - Outputs clear asynchronously (issue_valid=0, busy=0); no done.
  - After release, state is IDLE and start restarts from start_pc.
- Start while busy: pulse start during the loop test.
  - No restart: pc and loop_cnt sequence are unchanged vs the reference run.

Source files
------------

// File: rtl/ae_program_sequencer.sv
// Program sequencer: fetches from a synchronous instruction memory and issues decoded ops to the datapath.
// Latency: start -> first issue 2 cycles; 2 cycles per instruction without stall.
// Backpressure: stall holds a datapath issue in EXEC (outputs stable, pc frozen); LOOP_SET/LOOP_END/HALT ignore stall.
//
// Ports: clock/reset_n (async active-low); start/start_pc launch a program from IDLE;
// instr_addr/instr_data form the memory fetch path (data one cycle after address);
// issue_valid/opcode/field_1..3 go to the datapath, stall pushes back;
// busy is high outside IDLE, done pulses for one cycle on HALT.
module ae_program_sequencer #(
    parameter int INSTR_W = 16,
    parameter int FIELD_W = 4,
    parameter int PC_W    = 5,
    parameter int LOOP_W  = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [PC_W-1:0]    start_pc,
    output logic [PC_W-1:0]    instr_addr,
    input  logic [INSTR_W-1:0] instr_data,
    input  logic               stall,
    output logic               issue_valid,
    output logic [3:0]         opcode,
    output logic [FIELD_W-1:0] field_1,
    output logic [FIELD_W-1:0] field_2,
    output logic [FIELD_W-1:0] field_3,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     pc_inc;
    logic [PC_W-1:0]     pc_next;
    logic [PC_W-1:0]     loop_start;
    logic [LOOP_W-1:0]   loop_cnt;

    // While an issue is stalled the instruction word is held locally, so the
    // issued opcode/fields stay stable even if the memory output were to move.
    logic                hold_vld;
    logic [INSTR_W-1:0]  hold_instr;
    logic [INSTR_W-1:0]  instr;

    logic [3:0]          op;
    logic                is_dp;
    logic                is_loop_set;
    logic                is_loop_end;
    logic                is_halt;
    logic                in_exec;
    logic                stalled;
    logic                advance;

    assign instr       = hold_vld ? hold_instr : instr_data;
    assign op          = instr[INSTR_W-1 -: 4];
    assign is_dp       = (op <= 4'hC);
    assign is_loop_set = (op == 4'hD);
    assign is_loop_end = (op == 4'hE);
    assign is_halt     = (op == 4'hF);

    assign in_exec     = (state == EXEC);
    assign stalled     = in_exec && is_dp && stall;
    assign advance     = in_exec && !is_halt && !stalled;

    // Modular increment: the top address wraps to 0.
    assign pc_inc      = pc + PC_W'(1);
    assign pc_next     = (is_loop_end && (loop_cnt != '0)) ? loop_start : pc_inc;

    // The pc register is the memory address; no separate copy is kept.
    assign instr_addr  = pc;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   state_next = EXEC;
            EXEC: begin
                if (is_halt)      state_next = IDLE;
                else if (stalled) state_next = EXEC;
                else              state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    // Program counter, loop registers and stall hold
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc         <= '0;
            loop_cnt   <= '0;
            loop_start <= '0;
            hold_vld   <= 1'b0;
            hold_instr <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                pc <= start_pc;
            end else if (advance) begin
                pc <= pc_next;
            end

            // A LOOP_SET inside a running loop simply overwrites the loop state.
            if (in_exec && is_loop_set) begin
                loop_cnt   <= instr[LOOP_W-1:0];
                loop_start <= pc_inc;
            end else if (in_exec && is_loop_end && (loop_cnt != '0)) begin
                loop_cnt   <= loop_cnt - LOOP_W'(1);
            end

            hold_vld <= stalled;
            if (stalled) begin
                hold_instr <= instr;
            end
        end
    end

    // Outputs
    always_comb begin
        busy        = (state != IDLE);
        issue_valid = 1'b0;
        done        = 1'b0;
        opcode      = '0;
        field_1     = '0;
        field_2     = '0;
        field_3     = '0;
        if (in_exec) begin
            issue_valid = is_dp;
            done        = is_halt;
            opcode      = op;
            field_1     = instr[3*FIELD_W-1 -: FIELD_W];
            field_2     = instr[2*FIELD_W-1 -: FIELD_W];
            field_3     = instr[FIELD_W-1 -: FIELD_W];
        end
    end

endmodule

// File: tb/tb_ae_program_sequencer.sv
// Bench for ae_program_sequencer: directed scenarios plus randomized programs
// checked against a program-level interpreter of the instruction set.
module tb_ae_program_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  start_pc = '0;
    logic [4:0]  instr_addr;
    logic [15:0] instr_data;
    logic        stall = 1'b0;
    logic        issue_valid;
    logic [3:0]  opcode;
    logic [3:0]  field_1;
    logic [3:0]  field_2;
    logic [3:0]  field_3;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    ae_program_sequencer #(
        .INSTR_W(16), .FIELD_W(4), .PC_W(5), .LOOP_W(8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .start_pc   (start_pc),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .stall      (stall),
        .issue_valid(issue_valid),
        .opcode     (opcode),
        .field_1    (field_1),
        .field_2    (field_2),
        .field_3    (field_3),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Synchronous instruction memory: data one cycle after the address.
    logic [15:0] mem [32];
    always_ff @(posedge clock) instr_data <= mem[instr_addr];

    typedef struct {
        logic [3:0] op;
        logic [3:0] f1;
        logic [3:0] f2;
        logic [3:0] f3;
        logic [4:0] addr;
        int         cyc;
    } iss_t;

    // Observations of the last run (cycle 0 = cycle in which start is accepted)
    iss_t       obs[$];     // completed issues
    iss_t       raw[$];     // every cycle with issue_valid high
    logic [4:0] addr_tr[$]; // instr_addr per cycle
    int         done_cyc;
    int         done_cnt;
    logic       busy_at_done;
    logic       busy_after;

    // Reference model state (persists across runs like the loop registers do)
    iss_t       exp_q[$];
    int         exp_n;
    logic [7:0] m_lc = '0;
    logic [4:0] m_ls = '0;

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 16'hF000;
    endtask

    // Interprets the program from spc: records every datapath issue and the
    // number of executed instructions including the final HALT.
    task automatic model_run(input logic [4:0] spc);
        logic [4:0]  pc;
        logic [15:0] ins;
        iss_t        e;
        exp_q.delete();
        exp_n = 0;
        pc = spc;
        for (int s = 0; s < 1000; s++) begin
            ins = mem[pc];
            exp_n++;
            if (ins[15:12] == 4'hF) break;
            if (ins[15:12] <= 4'hC) begin
                e.op = ins[15:12]; e.f1 = ins[11:8]; e.f2 = ins[7:4]; e.f3 = ins[3:0];
                e.addr = pc; e.cyc = -1;
                exp_q.push_back(e);
                pc = pc + 5'd1;
            end else if (ins[15:12] == 4'hD) begin
                m_lc = ins[7:0];
                m_ls = pc + 5'd1;
                pc = pc + 5'd1;
            end else begin
                if (m_lc != 0) begin
                    m_lc = m_lc - 8'd1;
                    pc = m_ls;
                end else begin
                    pc = pc + 5'd1;
                end
            end
        end
    endtask

    // start_mode: 0 = single start pulse, 1 = random start noise, 2 = start held high
    task automatic run_prog(input logic [4:0] spc, input int stall_first, input bit rnd_stall,
                            input int start_mode, input int max_cyc);
        iss_t rec;
        int   scnt;
        bit   seen_done;
        obs.delete(); raw.delete(); addr_tr.delete();
        done_cyc = -1; done_cnt = 0; busy_at_done = 1'b0; busy_after = 1'b1;
        scnt = 0; seen_done = 1'b0;
        @(posedge clock); #1;
        start = 1'b1; start_pc = spc; stall = 1'b0;
        @(negedge clock);
        addr_tr.push_back(instr_addr);
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clock); #1;
            if (seen_done)            start = 1'b0;
            else if (start_mode == 0) start = 1'b0;
            else if (start_mode == 1) start = 1'($urandom_range(0, 1));
            else                      start = 1'b1;
            if (start_mode != 0) start_pc = 5'($urandom_range(0, 31));
            if (rnd_stall) stall = ($urandom_range(0, 2) == 0);
            else           stall = (obs.size() == 0) && (scnt < stall_first);
            @(negedge clock);
            addr_tr.push_back(instr_addr);
            if (seen_done) begin
                busy_after = busy;
                break;
            end
            if (issue_valid) begin
                rec.op = opcode; rec.f1 = field_1; rec.f2 = field_2; rec.f3 = field_3;
                rec.addr = instr_addr; rec.cyc = c;
                raw.push_back(rec);
                if (stall) scnt++;
                else       obs.push_back(rec);
            end
            if (done) begin
                done_cnt++;
                seen_done = 1'b1;
                done_cyc = c;
                busy_at_done = busy;
            end
        end
        start = 1'b0;
        stall = 1'b0;
        tests++;
        if (!seen_done) begin
            fails++;
            $display("FAIL run_timeout: no done within %0d cycles (start_pc=%0d)", max_cyc, spc);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; stall = 1'b0;
        clear_mem();
        m_lc = '0; m_ls = '0;
        #2;
        tests++;
        if ({issue_valid, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctrl: issue_valid/busy/done=%b required 000", {issue_valid, busy, done});
        end
        tests++;
        if ({opcode, field_1, field_2, field_3} !== 16'h0000) begin
            fails++;
            $display("FAIL reset_fields: got %h required 0000", {opcode, field_1, field_2, field_3});
        end
        tests++;
        if (instr_addr !== 5'd0) begin
            fails++;
            $display("FAIL reset_addr: got %0d required 0", instr_addr);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_straight_line();
        clear_mem();
        mem[0] = 16'h1123; mem[1] = 16'h2456; mem[2] = 16'hF000;
        run_prog(5'd0, 0, 1'b0, 0, 40);
        tests++;
        if (obs.size() != 2) begin
            fails++;
            $display("FAIL straight_count: %0d issues required 2", obs.size());
        end
        if (obs.size() >= 2) begin
            tests++;
            if ({obs[0].op, obs[0].f1, obs[0].f2, obs[0].f3} !== 16'h1123 || obs[0].cyc != 2) begin
                fails++;
                $display("FAIL straight_issue0: %h at cycle %0d required 1123 at 2",
                         {obs[0].op, obs[0].f1, obs[0].f2, obs[0].f3}, obs[0].cyc);
            end
            tests++;
            if ({obs[1].op, obs[1].f1, obs[1].f2, obs[1].f3} !== 16'h2456 || obs[1].cyc != 4) begin
                fails++;
                $display("FAIL straight_issue1: %h at cycle %0d required 2456 at 4",
                         {obs[1].op, obs[1].f1, obs[1].f2, obs[1].f3}, obs[1].cyc);
            end
        end
        tests++;
        if (done_cyc != 6 || done_cnt != 1 || busy_at_done !== 1'b1) begin
            fails++;
            $display("FAIL straight_done: cycle %0d count %0d busy %b required 6 1 1",
                     done_cyc, done_cnt, busy_at_done);
        end
        tests++;
        if (busy_after !== 1'b0) begin
            fails++;
            $display("FAIL straight_busy_after: busy=%b required 0", busy_after);
        end
    endtask

    task automatic test_stall();
        bit stable;
        clear_mem();
        mem[0] = 16'h1123; mem[1] = 16'h2456; mem[2] = 16'hF000;
        run_prog(5'd0, 3, 1'b0, 0, 40);
        stable = (raw.size() >= 4);
        for (int i = 0; i < 4 && i < raw.size(); i++) begin
            if ({raw[i].op, raw[i].f1, raw[i].f2, raw[i].f3} !== 16'h1123 ||
                raw[i].addr !== 5'd0 || raw[i].cyc != 2 + i) stable = 1'b0;
        end
        tests++;
        if (!stable) begin
            fails++;
            $display("FAIL stall_hold: %0d valid cycles, first issue not stable at addr 0 over cycles 2..5",
                     raw.size());
        end
        tests++;
        if (obs.size() != 2 || obs[obs.size()-1].cyc != 7) begin
            fails++;
            $display("FAIL stall_second_issue: %0d issues, last at cycle %0d required 2 with last at 7",
                     obs.size(), (obs.size() > 0) ? obs[obs.size()-1].cyc : -1);
        end
        tests++;
        if (done_cyc != 9) begin
            fails++;
            $display("FAIL stall_done: cycle %0d required 9", done_cyc);
        end
    endtask

    task automatic load_loop_prog();
        clear_mem();
        mem[0] = 16'hD002; mem[1] = 16'h3111; mem[2] = 16'hE000; mem[3] = 16'hF000;
    endtask

    task automatic check_against_model(input string name, input bit check_time);
        bit ok;
        ok = (obs.size() == exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            if ({obs[i].op, obs[i].f1, obs[i].f2, obs[i].f3, obs[i].addr} !==
                {exp_q[i].op, exp_q[i].f1, exp_q[i].f2, exp_q[i].f3, exp_q[i].addr}) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s_issues: %0d issues seen, %0d required, or content/address differs",
                     name, obs.size(), exp_q.size());
        end
        tests++;
        if (done_cnt != 1 || (check_time && done_cyc != 2 * exp_n)) begin
            fails++;
            $display("FAIL %s_done: count %0d at cycle %0d required 1 at %0d",
                     name, done_cnt, done_cyc, 2 * exp_n);
        end
        tests++;
        if (dut.loop_cnt !== m_lc) begin
            fails++;
            $display("FAIL %s_loop_cnt: got %0d required %0d", name, dut.loop_cnt, m_lc);
        end
    endtask

    task automatic test_loop();
        load_loop_prog();
        model_run(5'd0);
        run_prog(5'd0, 0, 1'b0, 0, 60);
        check_against_model("loop", 1'b1);
        tests++;
        if (obs.size() != 3 || done_cyc != 16) begin
            fails++;
            $display("FAIL loop_passes: %0d issues done at %0d required 3 done at 16", obs.size(), done_cyc);
        end
    endtask

    task automatic test_wrap();
        clear_mem();
        mem[31] = 16'h1000; mem[0] = 16'hF000;
        run_prog(5'd31, 0, 1'b0, 0, 40);
        tests++;
        if (obs.size() != 1 || obs[0].addr !== 5'd31 || obs[0].cyc != 2) begin
            fails++;
            $display("FAIL wrap_issue: %0d issues required one at addr 31 cycle 2", obs.size());
        end
        tests++;
        if (addr_tr.size() < 4 || addr_tr[3] !== 5'd0) begin
            fails++;
            $display("FAIL wrap_addr: instr_addr after wrap=%0d required 0",
                     (addr_tr.size() >= 4) ? int'(addr_tr[3]) : -1);
        end
        tests++;
        if (done_cyc != 4) begin
            fails++;
            $display("FAIL wrap_done: cycle %0d required 4", done_cyc);
        end
    endtask

    task automatic test_reset_midrun();
        bit got_issue;
        bit quiet;
        clear_mem();
        mem[0] = 16'h1123; mem[1] = 16'hF000;
        @(posedge clock); #1;
        start = 1'b1; start_pc = 5'd0; stall = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        got_issue = 1'b0;
        for (int c = 0; c < 10 && !got_issue; c++) begin
            @(negedge clock);
            got_issue = issue_valid;
        end
        tests++;
        if (!got_issue) begin
            fails++;
            $display("FAIL midrun_issue: issue_valid never high before reset");
        end
        #1 reset_n = 1'b0;
        m_lc = '0; m_ls = '0;
        #1;
        tests++;
        if ({issue_valid, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL midrun_async_clear: issue_valid/busy/done=%b required 000",
                     {issue_valid, busy, done});
        end
        stall = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
        end
        tests++;
        if (!quiet) begin
            fails++;
            $display("FAIL midrun_idle: busy or done seen after reset release, required idle");
        end
        mem[5] = 16'h4ABC; mem[6] = 16'hF000;
        run_prog(5'd5, 0, 1'b0, 0, 40);
        tests++;
        if (obs.size() != 1 || {obs[0].op, obs[0].f1, obs[0].f2, obs[0].f3} !== 16'h4ABC ||
            obs[0].addr !== 5'd5 || obs[0].cyc != 2 || done_cyc != 4) begin
            fails++;
            $display("FAIL midrun_restart: %0d issues, done at %0d required 4ABC at addr 5 cycle 2, done at 4",
                     obs.size(), done_cyc);
        end
    endtask

    task automatic test_start_while_busy();
        load_loop_prog();
        model_run(5'd0);
        run_prog(5'd0, 0, 1'b0, 2, 60);
        check_against_model("busy_start", 1'b1);
        tests++;
        if (busy_after !== 1'b0) begin
            fails++;
            $display("FAIL busy_start_restart: busy=%b after done with start held, required 0", busy_after);
        end
    endtask

    task automatic test_random();
        logic [4:0] spc;
        logic [4:0] p;
        bit         rs;
        for (int it = 0; it < 24; it++) begin
            clear_mem();
            spc = 5'($urandom_range(0, 31));
            p = spc;
            for (int k = 0; k < $urandom_range(0, 3); k++) begin
                if ($urandom_range(0, 4) == 0) mem[p] = {4'hE, 12'($urandom_range(0, 4095))};
                else mem[p] = {4'($urandom_range(0, 12)), 12'($urandom_range(0, 4095))};
                p = p + 5'd1;
            end
            if ($urandom_range(0, 3) != 0) begin
                mem[p] = {4'hD, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 4))};
                p = p + 5'd1;
                for (int k = 0; k < $urandom_range(1, 3); k++) begin
                    mem[p] = {4'($urandom_range(0, 12)), 12'($urandom_range(0, 4095))};
                    p = p + 5'd1;
                end
                mem[p] = {4'hE, 12'($urandom_range(0, 4095))};
                p = p + 5'd1;
            end
            for (int k = 0; k < $urandom_range(0, 2); k++) begin
                mem[p] = {4'($urandom_range(0, 12)), 12'($urandom_range(0, 4095))};
                p = p + 5'd1;
            end
            mem[p] = {4'hF, 12'($urandom_range(0, 4095))};
            rs = it[0];
            model_run(spc);
            run_prog(spc, 0, rs, 1, 600);
            check_against_model("random", !rs);
        end
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_stall();
        test_loop();
        test_wrap();
        test_reset_midrun();
        test_start_while_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
